gcd_ctrl: RTL and testbench

Control FSM for the subtractive GCD engine. It sequences operand loading into the A and B operand registers and the compare/subtract loop, using comparator and zero flags from the datapath. It drives the register load enables and datapath mux selects, counts iterations, and reports completion through a start/done level handshake. When `done=1` and `err=0`, the result is held in the A register.

---
 rtl/gcd_ctrl.sv | 124 ++++++++++++
 tb/tb_gcd_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// Control FSM for a subtractive GCD engine: loads operands, runs compare/subtract loop, flags errors.
// Latency 3+2N cycles from start to done for N iterations; start/done level handshake, no abort except reset.
module gcd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ITER_W     = 8,
    parameter int MAX_ITER   = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              start,
    input  logic              a_zero,
    input  logic              b_zero,
    input  logic              lt,
    input  logic              gt,
    input  logic              eq,
    output logic              ld_A,
    output logic              ld_B,
    output logic              sel_in,
    output logic              sel_sub,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_cnt
);

    generate
        if (DATA_WIDTH < 1 || MAX_ITER > (1 << ITER_W) - 1) begin : g_param_check
            $error("gcd_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CMP,
        SUB_A,
        SUB_B,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              err_nxt;
    logic [ITER_W-1:0] iter_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            err      <= 1'b0;
            iter_cnt <= '0;
        end else begin
            state    <= state_nxt;
            err      <= err_nxt;
            iter_cnt <= iter_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err;
        iter_nxt  = iter_cnt;
        ld_A      = 1'b0;
        ld_B      = 1'b0;
        sel_in    = 1'b0;
        sel_sub   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                ld_A      = 1'b1;
                ld_B      = 1'b1;
                sel_in    = 1'b1;
                busy      = 1'b1;
                err_nxt   = 1'b0;
                iter_nxt  = '0;
                state_nxt = CMP;
            end
            CMP: begin
                busy = 1'b1;
                // Zero operands never converge, so they outrank eq; the timeout
                // check sits ahead of any further subtraction so iter_cnt cannot wrap.
                if (a_zero || b_zero) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end else if (eq) begin
                    state_nxt = DONE;
                end else if (iter_cnt == ITER_W'(MAX_ITER)) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end else if (gt) begin
                    state_nxt = SUB_A;
                end else if (lt) begin
                    state_nxt = SUB_B;
                end else begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            SUB_A: begin
                ld_A      = 1'b1;
                busy      = 1'b1;
                iter_nxt  = iter_cnt + ITER_W'(1);
                state_nxt = CMP;
            end
            SUB_B: begin
                ld_B      = 1'b1;
                sel_sub   = 1'b1;
                busy      = 1'b1;
                iter_nxt  = iter_cnt + ITER_W'(1);
                state_nxt = CMP;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: two instances (default MAX_ITER and MAX_ITER=4) share stimulus, each with a
// modelled A/B datapath; a Euclid-based reference feeds per-instance scoreboards checked on done.
module tb_gcd_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: default MAX_ITER
    logic ld_a0, ld_b0, sel_in0, sel_sub0, busy0, done0, err0;
    logic [7:0] iter0, ra0, rb0;
    // Instance 1: MAX_ITER = 4
    logic ld_a1, ld_b1, sel_in1, sel_sub1, busy1, done1, err1;
    logic [7:0] iter1, ra1, rb1;

    gcd_ctrl u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .start(start),
        .a_zero(ra0 == 8'd0), .b_zero(rb0 == 8'd0),
        .lt(ra0 < rb0), .gt(ra0 > rb0), .eq(ra0 == rb0),
        .ld_A(ld_a0), .ld_B(ld_b0), .sel_in(sel_in0), .sel_sub(sel_sub0),
        .busy(busy0), .done(done0), .err(err0), .iter_cnt(iter0)
    );

    gcd_ctrl #(.MAX_ITER(4)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .start(start),
        .a_zero(ra1 == 8'd0), .b_zero(rb1 == 8'd0),
        .lt(ra1 < rb1), .gt(ra1 > rb1), .eq(ra1 == rb1),
        .ld_A(ld_a1), .ld_B(ld_b1), .sel_in(sel_in1), .sel_sub(sel_sub1),
        .busy(busy1), .done(done1), .err(err1), .iter_cnt(iter1)
    );

    always @(posedge clk) begin
        if (ld_a0) ra0 <= sel_in0 ? op_a : (sel_sub0 ? rb0 - ra0 : ra0 - rb0);
        if (ld_b0) rb0 <= sel_in0 ? op_b : (sel_sub0 ? rb0 - ra0 : ra0 - rb0);
        if (ld_a1) ra1 <= sel_in1 ? op_a : (sel_sub1 ? rb1 - ra1 : ra1 - rb1);
        if (ld_b1) rb1 <= sel_in1 ? op_b : (sel_sub1 ? rb1 - ra1 : ra1 - rb1);
    end

    typedef struct {
        logic err;
        int   iter;
        int   res;
        int   cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Subtractive step count = sum of Euclid quotients, minus one for the final exact division.
    function automatic exp_t ref_model(input int a, input int b, input int maxi, input int c0);
        exp_t e;
        int x, y, r, total;
        e.res = 0;
        if (a == 0 || b == 0) begin
            e.err  = 1'b1;
            e.iter = 0;
        end else begin
            x = a;
            y = b;
            total = 0;
            while (y != 0) begin
                total += x / y;
                r = x % y;
                x = y;
                y = r;
            end
            total -= 1;
            if (total <= maxi) begin
                e.err  = 1'b0;
                e.iter = total;
                e.res  = x;
            end else begin
                e.err  = 1'b1;
                e.iter = maxi;
            end
        end
        e.cyc = c0 + 3 + 2 * e.iter;
        return e;
    endfunction

    logic done0_q = 1'b0;
    logic done1_q = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done0 && !done0_q) begin
            if (q0.size() == 0) begin
                check("unexpected_done0", 1, 0);
            end else begin
                e = q0.pop_front();
                check("done_cycle0", cyc, e.cyc);
                check("err0", int'(err0), int'(e.err));
                check("iter0", int'(iter0), e.iter);
                check("busy_in_done0", int'(busy0), 1);
                if (!e.err) check("result0", int'(ra0), e.res);
            end
        end
        done0_q <= done0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1 && !done1_q) begin
            if (q1.size() == 0) begin
                check("unexpected_done1", 1, 0);
            end else begin
                e = q1.pop_front();
                check("done_cycle1", cyc, e.cyc);
                check("err1", int'(err1), int'(e.err));
                check("iter1", int'(iter1), e.iter);
                check("busy_in_done1", int'(busy1), 1);
                if (!e.err) check("result1", int'(ra1), e.res);
            end
        end
        done1_q <= done1;
    end

    task automatic check_idle(input string tag);
        check({tag, "_outs0"}, int'({ld_a0, ld_b0, sel_in0, sel_sub0, busy0, done0, err0}), 0);
        check({tag, "_iter0"}, int'(iter0), 0);
        check({tag, "_outs1"}, int'({ld_a1, ld_b1, sel_in1, sel_sub1, busy1, done1, err1}), 0);
        check({tag, "_iter1"}, int'(iter1), 0);
    endtask

    // Called at a negedge; runs one full handshake including a 5-cycle hold in DONE.
    task automatic run_op(input int a, input int b, input bit toggle);
        exp_t e0, e1;
        int k;
        op_a  = 8'(a);
        op_b  = 8'(b);
        start = 1'b1;
        e0 = ref_model(a, b, 255, cyc);
        e1 = ref_model(a, b, 4, cyc);
        q0.push_back(e0);
        q1.push_back(e1);
        if (toggle) begin
            repeat (3) @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1;
        end
        k = 0;
        while (!(done0 && done1) && k < 1200) begin
            @(negedge clk);
            k++;
        end
        check("wait_done_timeout", int'(k < 1200), 1);
        repeat (5) begin
            @(negedge clk);
            check("hold_done0", int'(done0), 1);
            check("hold_done1", int'(done1), 1);
        end
        start = 1'b0;
        @(negedge clk);
        check("idle_done0", int'({busy0, done0}), 0);
        check("idle_done1", int'({busy1, done1}), 0);
        check("kept_err0", int'(err0), int'(e0.err));
        check("kept_iter0", int'(iter0), e0.iter);
        check("kept_err1", int'(err1), int'(e1.err));
        check("kept_iter1", int'(iter1), e1.iter);
    endtask

    // Asserts reset ncyc edges into a computation; ncyc must differ from any done latency.
    task automatic reset_mid(input int a, input int b, input int ncyc);
        exp_t e0, e1;
        op_a  = 8'(a);
        op_b  = 8'(b);
        start = 1'b1;
        e0 = ref_model(a, b, 255, cyc);
        e1 = ref_model(a, b, 4, cyc);
        if (e0.cyc - (cyc) < ncyc) q0.push_back(e0);
        if (e1.cyc - (cyc) < ncyc) q1.push_back(e1);
        repeat (ncyc) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(12, 8, 1'b0);
        run_op(9, 9, 1'b0);
        run_op(0, 5, 1'b0);
        run_op(7, 0, 1'b0);
        run_op(255, 1, 1'b0);
        run_op(12, 8, 1'b1);
        run_op(5, 12, 1'b0);
        reset_mid(12, 8, 3);
        reset_mid(255, 1, 20);
        run_op(12, 8, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int a, b;
            if (i % 3 == 0) begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end
            run_op(a, b, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
